// File: rtl/param_serial_parity_checker_pkg.sv
// ---------------------------------------------------------------------------
// param_parity_pkg: shared FSM state type and parity-mode constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package param_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // High when the received parity disagrees with the selected mode.
  function automatic logic frame_err(input logic data_par, input logic par_bit,
                                     input logic mode);
    return data_par ^ par_bit ^ (mode == PAR_ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_serial_parity_checker_if.sv
// ---------------------------------------------------------------------------
// param_serial_parity_checker_if: serial input side and parallel/status outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface param_serial_parity_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) ();

  logic              odd_mode;
  logic              start;
  logic              bit_in;
  logic              bit_valid;
  logic              clr_cnt;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              parity_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;

  modport master (
    output odd_mode, start, bit_in, bit_valid, clr_cnt,
    input  busy, data_out, frame_valid, parity_err, err_cnt, err_sticky
  );

  modport slave (
    input  odd_mode, start, bit_in, bit_valid, clr_cnt,
    output busy, data_out, frame_valid, parity_err, err_cnt, err_sticky
  );

endinterface

`default_nettype wire

// File: rtl/param_serial_parity_checker_err_counter.sv
// ---------------------------------------------------------------------------
// parity_err_counter: saturating error counter with sticky flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module parity_err_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic [CNT_W-1:0]      cnt,
  output logic                  sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  // Clear is applied first so a coincident error still counts once.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (inc) begin
      sticky_d = 1'b1;
      if (cnt_d != CNT_MAX) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign cnt    = cnt_q;
  assign sticky = sticky_q;

endmodule

`default_nettype wire

// File: rtl/param_serial_parity_checker.sv
// ---------------------------------------------------------------------------
// param_serial_parity_checker: deserialises DATA_W bits plus parity, flags errors
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_serial_parity_checker
  import param_parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  param_serial_parity_checker_if.slave bus
);

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              odd_q, odd_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              fv_q, fv_d;
  logic              perr_q, perr_d;
  logic              err_inc;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    odd_d      = odd_q;
    data_out_d = data_out_q;
    perr_d     = perr_q;
    fv_d       = 1'b0;
    err_inc    = 1'b0;

    // start wins in every state: a frame in flight is dropped silently.
    if (bus.start) begin
      state_d  = DATA;
      bitcnt_d = '0;
      shreg_d  = '0;
      par_d    = 1'b0;
      odd_d    = bus.odd_mode;
    end else begin
      case (state_q)
        IDLE: ;
        DATA: begin
          if (bus.bit_valid) begin
            shreg_d[bitcnt_q] = bus.bit_in;
            par_d             = par_q ^ bus.bit_in;
            bitcnt_d          = bitcnt_q + BIT_W'(1);
            if (bitcnt_q == LAST_BIT) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (bus.bit_valid) begin
            state_d    = IDLE;
            fv_d       = 1'b1;
            data_out_d = shreg_q;
            perr_d     = frame_err(par_q, bus.bit_in, odd_q);
            err_inc    = perr_d;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      odd_q      <= PAR_EVEN;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      fv_q       <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      odd_q      <= odd_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      fv_q       <= fv_d;
      perr_q     <= perr_d;
    end
  end

  parity_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (err_inc),
    .clr    (bus.clr_cnt),
    .cnt    (err_cnt),
    .sticky (err_sticky)
  );

  assign bus.busy        = busy_q;
  assign bus.data_out    = data_out_q;
  assign bus.frame_valid = fv_q;
  assign bus.parity_err  = perr_q;
  assign bus.err_cnt     = err_cnt;
  assign bus.err_sticky  = err_sticky;

endmodule

`default_nettype wire
